// File: rtl/l2_arb_pkg.sv
// Shared definitions for the two-port L2 access arbiter.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector: the port that did not win last time wins a tie.
module rr_arb2
  import l2_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // one-hot grant from the two requests and the previous winner
  always_comb begin
    grant = 2'b00;
    if (req0 && (!req1 || (last_grant == PORT_D))) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/l2_access_arbiter.sv
// Shares one L2 cache port between the L1 instruction and data sides, one access
// in flight at a time, with a timeout guard and per-port accepted-request counters.
module l2_access_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              resp_valid,
  output logic              resp_id,
  output logic              resp_hit,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              l2_req,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic [DATA_W-1:0] l2_rdata,
  input  logic              l2_hit,
  input  logic              l2_miss,
  output logic              busy,
  output logic [31:0]       req_count0,
  output logic [31:0]       req_count1
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic       last_grant;
  logic       grant_id;
  logic [7:0] wait_cnt;
  logic [1:0] grant;
  logic       take;
  logic       sel;
  logic       l2_done;
  logic       timed_out;

  rr_arb2 u_rr_arb2 (
    .req0       (req0_valid),
    .req1       (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign take       = (state == IDLE) && (grant != 2'b00);
  assign sel        = grant[1];
  assign req0_ready = (state == IDLE) && grant[0];
  assign req1_ready = (state == IDLE) && grant[1];
  assign l2_done    = l2_hit || l2_miss;
  assign timed_out  = (wait_cnt == WAIT_LAST);
  assign busy       = (state != IDLE);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (take) next_state = ISSUE;
        else      next_state = IDLE;
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (l2_done || timed_out) next_state = IDLE;
        else                      next_state = WAIT;
      end
      default: next_state = IDLE;
    endcase
  end

  // L2 request fields load at the handshake so l2_req rises the cycle after it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PORT_D;
      grant_id   <= PORT_I;
      wait_cnt   <= 8'd0;
      l2_req     <= 1'b0;
      l2_write   <= 1'b0;
      l2_addr    <= {ADDR_W{1'b0}};
      l2_wdata   <= {DATA_W{1'b0}};
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= {DATA_W{1'b0}};
      req_count0 <= 32'd0;
      req_count1 <= 32'd0;
    end else begin
      l2_req     <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            last_grant <= sel;
            grant_id   <= sel;
            l2_req     <= 1'b1;
            l2_write   <= sel ? req1_write : req0_write;
            l2_addr    <= sel ? req1_addr  : req0_addr;
            l2_wdata   <= sel ? req1_wdata : req0_wdata;
            if (sel) req_count1 <= req_count1 + 32'd1;
            else     req_count0 <= req_count0 + 32'd1;
          end
        end
        ISSUE: wait_cnt <= 8'd0;
        WAIT: begin
          // a HIT/MISS arriving on the last allowed cycle still beats the timeout
          if (l2_done) begin
            resp_valid <= 1'b1;
            resp_id    <= grant_id;
            resp_hit   <= l2_hit;
            resp_err   <= 1'b0;
            resp_rdata <= l2_write ? {DATA_W{1'b0}} : l2_rdata;
          end else if (timed_out) begin
            resp_valid <= 1'b1;
            resp_id    <= grant_id;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b1;
            resp_rdata <= {DATA_W{1'b0}};
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: wait_cnt <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_access_arbiter.sv
// Directed bench for l2_access_arbiter: a transaction-level model predicts every
// output each cycle, and hand-computed literals pin the key scenarios.
module tb_l2_access_arbiter;

  localparam int TMO = 15;
  localparam int M_MISS = 0, M_HIT = 1, M_NONE = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id, resp_hit, resp_err;
  logic [31:0] resp_rdata;
  logic        l2_req, l2_write;
  logic [31:0] l2_addr, l2_wdata, l2_rdata;
  logic        l2_hit, l2_miss, busy;
  logic [31:0] req_count0, req_count1;

  int          l2_mode;
  logic [31:0] stub_rdata;

  int errors = 0;
  int checks = 0;

  // model state: time-stamped transactions rather than an FSM
  int          cyc, free_at, req_cycle, pulse_cycle, pend_due;
  bit          pend, pend_id, pend_hit, pend_err, m_lg;
  logic [31:0] pend_rdata, m_cnt0, m_cnt1, m_addr, m_wdata, m_rdata;
  bit          m_wr, m_rid, m_rhit, m_rerr;
  bit          glog[$];
  bit          rlog[$];

  always #5 clk = ~clk;

  l2_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_hit(resp_hit),
    .resp_err(resp_err), .resp_rdata(resp_rdata),
    .l2_req(l2_req), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_hit(l2_hit), .l2_miss(l2_miss), .busy(busy),
    .req_count0(req_count0), .req_count1(req_count1)
  );

  // L2 stub: registered HIT/MISS one cycle after the request pulse
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l2_hit <= 1'b0; l2_miss <= 1'b0; l2_rdata <= 32'd0;
    end else if (l2_req) begin
      l2_hit   <= (l2_mode == M_HIT);
      l2_miss  <= (l2_mode == M_MISS);
      l2_rdata <= stub_rdata;
    end else begin
      l2_hit <= 1'b0; l2_miss <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    free_at = 0; req_cycle = -1; pulse_cycle = -1; pend = 1'b0; pend_due = 0;
    m_lg = 1'b1; m_cnt0 = 32'd0; m_cnt1 = 32'd0;
    m_wr = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
    m_rid = 1'b0; m_rhit = 1'b0; m_rerr = 1'b0; m_rdata = 32'd0;
  endtask

  // one cycle: compare everything at the falling edge, advance the model at the rising edge
  task automatic tick();
    bit idle, g0, g1, id;
    @(negedge clk);
    idle = (cyc >= free_at);
    g0 = idle && req0_valid && (!req1_valid || m_lg);
    g1 = idle && req1_valid && (!req0_valid || !m_lg);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    chk("busy", {31'd0, busy}, {31'd0, !idle});
    chk("l2_req", {31'd0, l2_req}, {31'd0, cyc == req_cycle});
    chk("l2_write", {31'd0, l2_write}, {31'd0, m_wr});
    chk("l2_addr", l2_addr, m_addr);
    chk("l2_wdata", l2_wdata, m_wdata);
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, cyc == pulse_cycle});
    chk("resp_id", {31'd0, resp_id}, {31'd0, m_rid});
    chk("resp_hit", {31'd0, resp_hit}, {31'd0, m_rhit});
    chk("resp_err", {31'd0, resp_err}, {31'd0, m_rerr});
    chk("resp_rdata", resp_rdata, m_rdata);
    chk("req_count0", req_count0, m_cnt0);
    chk("req_count1", req_count1, m_cnt1);
    if (resp_valid) rlog.push_back(resp_id);
    @(posedge clk);
    if (g0 || g1) begin
      id = g1;
      m_lg = id;
      glog.push_back(id);
      if (id) m_cnt1 = m_cnt1 + 32'd1;
      else    m_cnt0 = m_cnt0 + 32'd1;
      m_wr    = id ? req1_write : req0_write;
      m_addr  = id ? req1_addr  : req0_addr;
      m_wdata = id ? req1_wdata : req0_wdata;
      req_cycle = cyc + 1;
      pend = 1'b1;
      pend_id = id;
      if (l2_mode == M_NONE) begin
        pend_due = cyc + 2 + TMO; pend_err = 1'b1; pend_hit = 1'b0; pend_rdata = 32'd0;
      end else begin
        pend_due = cyc + 3; pend_err = 1'b0; pend_hit = (l2_mode == M_HIT);
        pend_rdata = m_wr ? 32'd0 : stub_rdata;
      end
      free_at = pend_due;
    end
    cyc++;
    if (pend && cyc == pend_due) begin
      m_rid = pend_id; m_rhit = pend_hit; m_rerr = pend_err; m_rdata = pend_rdata;
      pend = 1'b0; pulse_cycle = cyc;
    end
    #1;
  endtask

  // asynchronous reset taken between edges; outputs must clear at once
  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst l2_req", {31'd0, l2_req}, 32'd0);
    chk("rst l2_write", {31'd0, l2_write}, 32'd0);
    chk("rst l2_addr", l2_addr, 32'd0);
    chk("rst l2_wdata", l2_wdata, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_flags", {29'd0, resp_id, resp_hit, resp_err}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst req_count0", req_count0, 32'd0);
    chk("rst req_count1", req_count1, 32'd0);
    chk("rst ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, k1, gl;
    cyc = 0;
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = 32'd0; req0_wdata = 32'd0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = 32'd0; req1_wdata = 32'd0;
    l2_mode = M_MISS; stub_rdata = 32'd0;
    do_reset();

    // single read from port 0, L2 misses
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h0000_0404;
    stub_rdata = 32'hDEAD_BEEF; l2_mode = M_MISS;
    tick();
    req0_valid = 1'b0;
    chk("t1 l2_req pulse", {31'd0, l2_req}, 32'd1);
    chk("t1 l2_addr", l2_addr, 32'h0000_0404);
    tick();
    chk("t1 l2_req low", {31'd0, l2_req}, 32'd0);
    tick();
    chk("t1 resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("t1 resp flags", {29'd0, resp_id, resp_hit, resp_err}, 32'd0);
    chk("t1 resp_rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("t1 req_count0", req_count0, 32'd1);
    tick();
    chk("t1 resp pulse ends", {31'd0, resp_valid}, 32'd0);
    chk("t1 resp_rdata held", resp_rdata, 32'hDEAD_BEEF);

    // both ports continuously valid: 4 reads on port 0, 4 writes on port 1
    do_reset();
    glog.delete(); rlog.delete();
    k0 = 0; k1 = 0; l2_mode = M_HIT; stub_rdata = 32'hCAFE_F00D;
    for (int n = 0; n < 60 && (k0 < 4 || k1 < 4); n++) begin
      req0_valid = (k0 < 4); req0_write = 1'b0; req0_addr = 32'h100 + 32'(k0 * 4);
      req1_valid = (k1 < 4); req1_write = 1'b1; req1_addr = 32'h200 + 32'(k1 * 4);
      req1_wdata = 32'h1111_0000 + 32'(k1);
      gl = glog.size();
      tick();
      if (glog.size() > gl) begin
        if (glog[$]) k1++;
        else         k0++;
      end
    end
    chk("t2 all granted", 32'(k0 + k1), 32'd8);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    chk("t2 req_count0", req_count0, 32'd4);
    chk("t2 req_count1", req_count1, 32'd4);
    chk("t2 model grants", 32'(glog.size()), 32'd8);
    chk("t2 dut responses", 32'(rlog.size()), 32'd8);
    for (int i = 0; i < 8 && i < glog.size() && i < rlog.size(); i++) begin
      chk("t2 model grant order", {31'd0, glog[i]}, 32'(i % 2));
      chk("t2 resp_id order", {31'd0, rlog[i]}, 32'(i % 2));
    end

    // port 1 alone, then port 0 arrives while port 1 is waiting
    l2_mode = M_MISS; stub_rdata = 32'h1234_5678;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h300;
    tick();
    tick();
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h400;
    #1;
    chk("t3 ready0 in WAIT", {31'd0, req0_ready}, 32'd0);
    chk("t3 ready1 in WAIT", {31'd0, req1_ready}, 32'd0);
    tick();
    chk("t3 resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("t3 resp_id", {31'd0, resp_id}, 32'd1);
    chk("t3 resp_rdata", resp_rdata, 32'h1234_5678);
    chk("t3 ready0 wins", {31'd0, req0_ready}, 32'd1);
    chk("t3 ready1 loses", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3 port0 issued", l2_addr, 32'h400);
    for (int n = 0; n < 3; n++) tick();

    // L2 never answers: error response TMO cycles after entering WAIT
    l2_mode = M_NONE;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h500; req0_wdata = 32'hA5A5_A5A5;
    tick();
    req0_valid = 1'b0;
    tick();
    for (int n = 0; n < TMO - 1; n++) begin
      tick();
      chk("t4 no early resp", {31'd0, resp_valid}, 32'd0);
    end
    tick();
    chk("t4 timeout resp", {31'd0, resp_valid}, 32'd1);
    chk("t4 err/hit", {30'd0, resp_err, resp_hit}, 32'd2);
    chk("t4 rdata zero", resp_rdata, 32'd0);
    l2_mode = M_MISS;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h580;
    #1;
    chk("t4 accepts next", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    chk("t4 next issued", {31'd0, l2_req}, 32'd1);
    chk("t4 next addr", l2_addr, 32'h580);
    for (int n = 0; n < 3; n++) tick();

    // reset during WAIT drops the request; port 0 wins afterwards
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h600;
    tick();
    req1_valid = 1'b0;
    tick();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("t5 no dropped resp", {31'd0, resp_valid}, 32'd0);
    end
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h700;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h704;
    #1;
    chk("t5 ready0 after reset", {31'd0, req0_ready}, 32'd1);
    chk("t5 ready1 after reset", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t5 port0 addr", l2_addr, 32'h700);
    chk("t5 counts", {req_count0[15:0], req_count1[15:0]}, 32'h0001_0000);
    for (int n = 0; n < 3; n++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
